taxi_meter_ctrl: RTL and testbench
==================================

// Module: taxi_meter_ctrl
// PURPOSE
//  Trip controller for the taxi meter. Sequences the distance/low-speed-time datapath via
//  stop_state and pause_state, and classifies vehicle speed from wheel pulses (high_speed/low_speed).
//  Computes a live fare from the datapath's distance and low_time, and latches the final fare at trip end.
//  Sits between the button/debounce front end and the datapath and display.
// PARAMETERS
//  WINDOW_CYCLES  100   clk cycles per speed-measurement window
//  LOW_THRESH     10    wheel pulses per window below which speed is classified low
//  BASE_FARE      10    fare units covering the first BASE_DIST metres
//  BASE_DIST      2000  metres included in BASE_FARE
//  UNIT_DIST      1000  metres per distance charge unit beyond BASE_DIST
//  UNIT_PRICE     2     fare units per whole UNIT_DIST
//  LOW_PRICE      1     fare units per low_time minute
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  start_btn    in   1   one-cycle pulse, clk-synchronous
//  pause_btn    in   1   one-cycle pulse, clk-synchronous
//  stop_btn     in   1   one-cycle pulse, clk-synchronous
//  wheel_clk    in   1   raw wheel sensor, asynchronous to clk
//  distance     in   32  metres, from datapath
//  low_time     in   32  low-speed minutes, from datapath
//  stop_state   out  1   datapath clear
//  pause_state  out  1   datapath distance hold
//  high_speed   out  1   speed class high
//  low_speed    out  1   speed class low
//  fare         out  16  live fare during a trip; settled fare when IDLE
//  trip_state   out  2   IDLE=0, RUN=1, PAUSE=2, SETTLE=3
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, stop_state=1, pause_state=0, high_speed=0, low_speed=0, fare=0.
//   - Window counter and pulse counter cleared.
//  FSM, button priority stop > pause > start; only the highest-priority button is acted on in a cycle:
//   - IDLE:   start -> RUN. Pause and stop are ignored.
//   - RUN:    stop -> SETTLE; pause -> PAUSE.
//   - PAUSE:  stop -> SETTLE; pause or start -> RUN.
//   - SETTLE: unconditionally -> IDLE after one cycle. Buttons are ignored.
//  Outputs are Moore, registered, and change the cycle after the state transition:
//   - stop_state=1 only in IDLE. It is 0 in SETTLE so distance/low_time stay valid while the fare is latched.
//   - pause_state=1 only in PAUSE.
//  Wheel input:
//   - 2-flop synchroniser, then rising-edge detect gives a one-cycle wheel_tick.
//   - Latency from wheel_clk edge to tick: 3 clk cycles.
//  Speed classifier:
//   - Active in RUN only. Window counter counts 0..WINDOW_CYCLES-1.
//   - Pulse counter is 8 bits and saturates at 255.
//   - At window terminal: if count < LOW_THRESH then low_speed=1, high_speed=0; else the reverse.
//   - The pulse counter is then reset. A tick in the terminal cycle counts toward the new window (count=1).
//   - Entering RUN from IDLE or PAUSE restarts the window. high_speed=low_speed=0 until the first window completes.
//   - In PAUSE, SETTLE and IDLE: both speed flags are 0 and the counters are held cleared.
//  Fare, 1-cycle registered latency from distance/low_time:
//   - excess = (distance > BASE_DIST) ? distance - BASE_DIST : 0
//   - live = BASE_FARE + (excess / UNIT_DIST) * UNIT_PRICE + low_time * LOW_PRICE
//   - Computed in 40-bit intermediates; saturates at 16'hFFFF.
//   - RUN/PAUSE: fare = live.
//   - SETTLE: fare = live (final value) and is latched.
//   - IDLE: fare holds the latched value until the next start. On start, fare shows live, which is BASE_FARE once the datapath has cleared.
//  Reset mid-trip: immediate return to the IDLE reset values; the settled fare is lost.
// STRUCTURE
//  - Shared header taxi_defs.vh: trip_state encodings (IDLE/RUN/PAUSE/SETTLE), FARE_W=16, SPEED_CNT_W=8.
//  - Sub-module taxi_speed_classifier: contains the synchroniser, edge detect, window and pulse counters.
//    Interface: enable input plus high_speed/low_speed outputs.
//  - Top level holds the FSM and the fare arithmetic.
// TESTING
//  - Reset then start; 12 wheel edges per 100-cycle window -> high_speed=1 after window 1; stop_state 1->0 at start.
//  - RUN with 5 edges/window -> low_speed=1 at the window end; pause -> low_speed=0, pause_state=1 next cycle.
//  - distance=3500, low_time=3 in RUN -> fare=15 one cycle later; distance=1999, low_time=0 -> fare=10.
//  - stop in RUN with fare=15 -> SETTLE one cycle, IDLE with stop_state=1; fare stays 15 while distance is cleared to 0.
//  - Same-cycle start+pause+stop in RUN -> SETTLE. pause+start in PAUSE -> RUN. start in SETTLE -> ignored.
//  - distance=32'hFFFF_FFFF -> fare=16'hFFFF. rst_n low mid-PAUSE -> immediate IDLE, fare=0.

Source files
------------

// File: rtl/taxi_meter_ctrl_pkg.sv
// Shared definitions for the taxi meter trip controller.
//  - trip_state_e : trip FSM encoding, also driven straight onto the trip_state port
//  - FARE_W       : width of the displayed fare
//  - SPEED_CNT_W  : width of the per-window wheel pulse counter
//  - CALC_W       : width of the fare arithmetic intermediates
//  - sat_fare()   : clamps a wide fare value to the displayable range
package taxi_meter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        SETTLE = 2'd3
    } trip_state_e;

    localparam int FARE_W      = 16;
    localparam int SPEED_CNT_W = 8;
    localparam int CALC_W      = 40;

    function automatic logic [FARE_W-1:0] sat_fare(input logic [CALC_W-1:0] v);
        if (v > CALC_W'({FARE_W{1'b1}}))
            return {FARE_W{1'b1}};
        else
            return v[FARE_W-1:0];
    endfunction

endpackage

// File: rtl/taxi_meter_ctrl_speed_classifier.sv
// Wheel speed classifier.
// Synchronises the raw wheel sensor, turns each rising edge into a one-cycle
// tick and counts ticks over fixed windows of WINDOW_CYCLES clocks. At every
// window end the speed class is re-evaluated against LOW_THRESH.
// Ports:
//  clk, rst_n    : clock, asynchronous active-low reset
//  enable_i      : classifier runs only while high; counters and flags cleared otherwise
//  wheel_clk_i   : raw wheel sensor, asynchronous to clk
//  high_speed_o  : registered, last completed window had >= LOW_THRESH pulses
//  low_speed_o   : registered, last completed window had <  LOW_THRESH pulses
module taxi_speed_classifier
    import taxi_meter_ctrl_pkg::*;
#(
    parameter int WINDOW_CYCLES = 100,
    parameter int LOW_THRESH    = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic wheel_clk_i,
    output logic high_speed_o,
    output logic low_speed_o
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    logic                   sync1_q, sync2_q, sync3_q, tick_q;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [SPEED_CNT_W-1:0] cnt_q, cnt_d;
    logic                   hs_q, hs_d, ls_q, ls_d;
    logic                   below_thresh;

    // Two synchroniser flops, one history flop and a registered tick:
    // a wheel edge shows up as tick_q three clocks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= wheel_clk_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            tick_q  <= sync2_q & ~sync3_q;
        end
    end

    assign below_thresh = 32'(cnt_q) < 32'(LOW_THRESH);

    always_comb begin
        win_d = win_q;
        cnt_d = cnt_q;
        hs_d  = hs_q;
        ls_d  = ls_q;
        if (!enable_i) begin
            win_d = '0;
            cnt_d = '0;
            hs_d  = 1'b0;
            ls_d  = 1'b0;
        end else if (win_q == WIN_LAST) begin
            // Classify on pulses of the closing window; a tick landing in
            // this cycle opens the new window's count.
            win_d = '0;
            cnt_d = {{(SPEED_CNT_W-1){1'b0}}, tick_q};
            ls_d  = below_thresh;
            hs_d  = ~below_thresh;
        end else begin
            win_d = win_q + 1'b1;
            if (tick_q && (cnt_q != {SPEED_CNT_W{1'b1}}))
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
            cnt_q <= '0;
            hs_q  <= 1'b0;
            ls_q  <= 1'b0;
        end else begin
            win_q <= win_d;
            cnt_q <= cnt_d;
            hs_q  <= hs_d;
            ls_q  <= ls_d;
        end
    end

    assign high_speed_o = hs_q;
    assign low_speed_o  = ls_q;

endmodule

// File: rtl/taxi_meter_ctrl.sv
// Taxi meter trip controller.
// Runs the trip FSM (IDLE/RUN/PAUSE/SETTLE), drives the datapath control
// lines, hosts the wheel speed classifier and computes the fare from the
// datapath's distance and low-speed time. The fare settled in SETTLE is held
// through IDLE until the next trip starts.
// Ports:
//  clk, rst_n                     : clock, asynchronous active-low reset
//  start_btn/pause_btn/stop_btn   : one-cycle button pulses, priority stop > pause > start
//  wheel_clk                      : raw wheel sensor, asynchronous
//  distance, low_time             : datapath metres and low-speed minutes
//  stop_state                     : datapath clear, high only in IDLE
//  pause_state                    : datapath distance hold, high only in PAUSE
//  high_speed, low_speed          : speed class from the classifier
//  fare                           : live fare in a trip, settled fare in IDLE
//  trip_state                     : current FSM state
module taxi_meter_ctrl
    import taxi_meter_ctrl_pkg::*;
#(
    parameter int WINDOW_CYCLES = 100,
    parameter int LOW_THRESH    = 10,
    parameter int BASE_FARE     = 10,
    parameter int BASE_DIST     = 2000,
    parameter int UNIT_DIST     = 1000,
    parameter int UNIT_PRICE    = 2,
    parameter int LOW_PRICE     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_btn,
    input  logic              pause_btn,
    input  logic              stop_btn,
    input  logic              wheel_clk,
    input  logic [31:0]       distance,
    input  logic [31:0]       low_time,
    output logic              stop_state,
    output logic              pause_state,
    output logic              high_speed,
    output logic              low_speed,
    output logic [FARE_W-1:0] fare,
    output logic [1:0]        trip_state
);

    trip_state_e       state_q;
    logic              stop_q, pause_q;
    logic [FARE_W-1:0] fare_q, fare_d;
    logic [CALC_W-1:0] excess, units, live;

    // Trip FSM with Moore outputs registered from the current state, so
    // stop_state/pause_state follow a transition by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stop_q  <= 1'b1;
            pause_q <= 1'b0;
        end else begin
            stop_q  <= (state_q == IDLE);
            pause_q <= (state_q == PAUSE);
            case (state_q)
                IDLE: begin
                    if (start_btn) state_q <= RUN;
                end
                RUN: begin
                    if (stop_btn)       state_q <= SETTLE;
                    else if (pause_btn) state_q <= PAUSE;
                end
                PAUSE: begin
                    if (stop_btn)                    state_q <= SETTLE;
                    else if (pause_btn || start_btn) state_q <= RUN;
                end
                SETTLE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    taxi_speed_classifier #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .LOW_THRESH    (LOW_THRESH)
    ) u_speed (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (state_q == RUN),
        .wheel_clk_i  (wheel_clk),
        .high_speed_o (high_speed),
        .low_speed_o  (low_speed)
    );

    // Fare arithmetic in wide intermediates so nothing wraps before the clamp.
    always_comb begin
        excess = (distance > 32'(BASE_DIST)) ? CALC_W'(distance - 32'(BASE_DIST)) : '0;
        units  = excess / CALC_W'(UNIT_DIST);
        live   = CALC_W'(BASE_FARE) + units * CALC_W'(UNIT_PRICE)
               + CALC_W'(low_time) * CALC_W'(LOW_PRICE);
    end

    // Tracking the live value through SETTLE and freezing it in IDLE is what
    // latches the final fare while the datapath clears.
    assign fare_d = (state_q == IDLE) ? fare_q : sat_fare(live);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fare_q <= '0;
        else        fare_q <= fare_d;
    end

    assign stop_state  = stop_q;
    assign pause_state = pause_q;
    assign fare        = fare_q;
    assign trip_state  = state_q;

endmodule

// File: tb/tb_taxi_meter_ctrl.sv
// Bench for taxi_meter_ctrl: directed stimulus pushes cycle-stamped expected
// values into a queue; a monitor on the falling edge pops and compares them.
module tb_taxi_meter_ctrl;

    localparam int S_ST = 0, S_STOP = 1, S_PS = 2, S_HS = 3, S_LS = 4, S_FARE = 5;
    localparam logic [31:0] ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_SETTLE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_btn = 1'b0, pause_btn = 1'b0, stop_btn = 1'b0;
    logic        wheel_clk = 1'b0;
    logic [31:0] distance = '0, low_time = '0;
    logic        stop_state, pause_state, high_speed, low_speed;
    logic [15:0] fare;
    logic [1:0]  trip_state;

    taxi_meter_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_btn   (start_btn),
        .pause_btn   (pause_btn),
        .stop_btn    (stop_btn),
        .wheel_clk   (wheel_clk),
        .distance    (distance),
        .low_time    (low_time),
        .stop_state  (stop_state),
        .pause_state (pause_state),
        .high_speed  (high_speed),
        .low_speed   (low_speed),
        .fare        (fare),
        .trip_state  (trip_state)
    );

    always #5 clk = ~clk;

    // Wheel sensor: free-running square wave with half period wheel_half ns,
    // offset from the clock so it is genuinely asynchronous.
    int wheel_half = 0;
    initial begin
        #3;
        forever begin
            if (wheel_half == 0) begin
                wheel_clk = 1'b0;
                #10;
            end else begin
                #(wheel_half) wheel_clk = ~wheel_clk;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input int d, input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + d;
        e.sel  = sel;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    function automatic logic [31:0] get_out(input int sel);
        case (sel)
            S_ST:    return {30'b0, trip_state};
            S_STOP:  return {31'b0, stop_state};
            S_PS:    return {31'b0, pause_state};
            S_HS:    return {31'b0, high_speed};
            S_LS:    return {31'b0, low_speed};
            default: return {16'b0, fare};
        endcase
    endfunction

    exp_t        m_e;
    logic [31:0] m_act;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e   = q.pop_front();
            m_act = get_out(m_e.sel);
            n_cmp++;
            if (m_e.cyc != cyc || m_act !== m_e.val) begin
                n_bad++;
                $display("FAIL %s: got %0h, expected %0h at cycle %0d (checked at %0d)",
                         m_e.name, m_act, m_e.val, m_e.cyc, cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #200us;
        n_bad++;
        $display("FAIL watchdog: bench still running at %0t, expected to finish", $time);
        summary();
        $finish;
    end

    logic [31:0] f_dist[8] = '{32'd3500, 32'd1999, 32'd2000, 32'd2999,
                               32'd3000, 32'hFFFF_FFFF, 32'd0, 32'd3500};
    logic [31:0] f_lt[8]   = '{32'd3, 32'd0, 32'd5, 32'd0,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] f_exp[8]  = '{32'd15, 32'd10, 32'd15, 32'd10,
                               32'd12, 32'hFFFF, 32'hFFFF, 32'd15};

    int t0;
    initial begin
        // Reset values
        tick(1);
        chk(0, S_ST,   ST_IDLE, "reset_state");
        chk(0, S_STOP, 1,       "reset_stop_state");
        chk(0, S_PS,   0,       "reset_pause_state");
        chk(0, S_HS,   0,       "reset_high_speed");
        chk(0, S_LS,   0,       "reset_low_speed");
        chk(0, S_FARE, 0,       "reset_fare");
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Start with ~12 wheel edges per window -> high after first window
        wheel_half = 40;
        t0 = cyc;
        chk(1, S_ST,   ST_RUN, "start_to_run");
        chk(1, S_STOP, 1,      "stop_state_lag");
        chk(2, S_STOP, 0,      "stop_state_cleared");
        start_btn = 1'b1; tick(1); start_btn = 1'b0;
        wait_until(t0 + 99);
        chk(1, S_HS, 0, "high_before_window_end");
        chk(2, S_HS, 1, "high_after_window1");
        chk(2, S_LS, 0, "low_after_window1");

        // Drop to ~5 edges per window -> low
        wheel_half = 100;
        wait_until(t0 + 300);
        chk(1, S_LS, 1, "low_after_window3");
        chk(1, S_HS, 0, "high_clear_window3");
        tick(2);

        // Pause: flags clear and pause_state rises the cycle after the state change
        chk(1, S_ST, ST_PAUSE, "run_to_pause");
        chk(1, S_PS, 0,        "pause_state_lag");
        chk(1, S_LS, 1,        "low_held_one_cycle");
        chk(2, S_PS, 1,        "pause_state_set");
        chk(2, S_LS, 0,        "low_cleared_in_pause");
        pause_btn = 1'b1; tick(1); pause_btn = 1'b0;
        tick(3);

        // pause+start in PAUSE resumes
        chk(1, S_ST, ST_RUN, "pause_start_to_run");
        pause_btn = 1'b1; start_btn = 1'b1; tick(1);
        pause_btn = 1'b0; start_btn = 1'b0;
        tick(2);

        // Fare table, one-cycle latency
        for (int i = 0; i < 8; i++) begin
            distance = f_dist[i];
            low_time = f_lt[i];
            chk(1, S_FARE, f_exp[i], $sformatf("fare_vec%0d", i));
            tick(1);
        end

        // Stop in RUN: settle, latch 15, keep it while datapath clears
        chk(1, S_ST,   ST_SETTLE, "run_to_settle");
        chk(2, S_ST,   ST_IDLE,   "settle_to_idle");
        chk(2, S_STOP, 0,         "stop_state_low_in_settle");
        chk(3, S_STOP, 1,         "stop_state_idle");
        chk(3, S_FARE, 15,        "fare_latched");
        stop_btn = 1'b1; tick(1); stop_btn = 1'b0; tick(1);
        distance = '0; low_time = '0;
        chk(3, S_FARE, 15, "fare_held_after_clear");
        tick(4);

        // Pause and stop ignored in IDLE
        chk(1, S_ST, ST_IDLE, "idle_ignores_pause");
        chk(2, S_ST, ST_IDLE, "idle_ignores_stop");
        pause_btn = 1'b1; tick(1); pause_btn = 1'b0;
        stop_btn = 1'b1; tick(1); stop_btn = 1'b0;
        tick(2);

        // New trip: settled fare until RUN, then live base fare
        chk(1, S_ST,   ST_RUN, "restart_run");
        chk(1, S_FARE, 15,     "fare_held_at_start");
        chk(2, S_FARE, 10,     "fare_base_on_start");
        start_btn = 1'b1; tick(1); start_btn = 1'b0;
        tick(2);

        // All three buttons in RUN -> SETTLE; start in SETTLE ignored
        chk(1, S_ST, ST_SETTLE, "all_buttons_settle");
        start_btn = 1'b1; pause_btn = 1'b1; stop_btn = 1'b1; tick(1);
        pause_btn = 1'b0; stop_btn = 1'b0;
        chk(1, S_ST, ST_IDLE, "settle_ignores_start");
        chk(2, S_ST, ST_IDLE, "still_idle");
        tick(1); start_btn = 1'b0;
        tick(2);

        // Reset in the middle of PAUSE
        distance = 32'd3500; low_time = 32'd3;
        start_btn = 1'b1; tick(1); start_btn = 1'b0; tick(1);
        pause_btn = 1'b1; tick(1); pause_btn = 1'b0; tick(2);
        chk(0, S_ST,   ST_PAUSE, "pause_before_reset");
        chk(0, S_PS,   1,        "pause_state_before_reset");
        chk(0, S_FARE, 15,       "fare_in_pause");
        tick(1);
        rst_n = 1'b0;
        chk(0, S_ST,   ST_IDLE, "midtrip_reset_state");
        chk(0, S_FARE, 0,       "midtrip_reset_fare");
        chk(0, S_STOP, 1,       "midtrip_reset_stop_state");
        chk(0, S_PS,   0,       "midtrip_reset_pause_state");
        tick(2);
        rst_n = 1'b1;
        tick(3);

        if (q.size() != 0) begin
            $display("FAIL leftover_checks: got %0d pending, expected 0", q.size());
            n_cmp += q.size();
            n_bad += q.size();
        end
        summary();
        $finish;
    end

endmodule
